deserializer: RTL and testbench



---
 rtl/deserializer_pkg.sv | 14 +
 rtl/deserializer_sync_fifo.sv | 63 ++++++
 rtl/deserializer.sv | 131 +++++++++++++
 tb/tb_deserializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and sizing helpers for the LSB-first serial receive stage.
package deser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_e;

  // One bit wider than log2 so the counter can represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/deserializer_sync_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_do;
  logic             pop_do;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_do  = pop & ~empty;
  assign push_do = push & (~full | pop_do);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_do) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_do)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign mem_d[gi] = (push_do && (wr_ptr_q[AW-1:0] == AW'(gi))) ? push_data : mem_q[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q[gi] <= '0;
        else        mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: assembles LSB-first words under a bit strobe
// and frame marker, buffering completed words for a valid/ready consumer.
module deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_data,
  input  logic             bit_en,
  input  logic             frame_start,
  input  logic             clr_status,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;

  logic start_bit;
  logic abort;
  logic complete;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic drop;
  logic push;

  assign start_bit = bit_en & frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_bit) state_d = RECV;
      RECV: if (bit_en && !frame_start && bit_cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A frame_start inside RECV restarts the word; the current bit becomes bit 0.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    abort     = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_bit) begin
          shreg_d   = {serial_data, {(WIDTH-1){1'b0}}};
          bit_cnt_d = CW'(1);
        end
      end
      RECV: begin
        if (start_bit) begin
          abort     = 1'b1;
          shreg_d   = {serial_data, {(WIDTH-1){1'b0}}};
          bit_cnt_d = CW'(1);
        end else if (bit_en) begin
          shreg_d = {serial_data, shreg_q[WIDTH-1:1]};
          if (bit_cnt_q == LAST) begin
            complete  = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign pop  = m_valid & m_ready;
  assign drop = complete & fifo_full & ~pop;
  assign push = complete & ~drop;

  always_comb begin
    overflow_d  = drop | (overflow_q & ~clr_status);
    frame_err_d = abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg_d),
    .pop       (pop),
    .rd_data   (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid   = ~fifo_empty;
  assign busy      = (state_q == RECV);
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer at WIDTH=8, DEPTH=2.
module tb_deserializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             serial_data = 1'b0;
  logic             bit_en = 1'b0;
  logic             frame_start = 1'b0;
  logic             clr_status = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic             busy;
  logic             overflow;
  logic             frame_err;

  int nvec = 0;
  int nerr = 0;
  int vld_cnt = 0;
  int ferr_cnt = 0;
  logic [WIDTH-1:0] exp_q [$];

  deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .serial_data (serial_data),
    .bit_en      (bit_en),
    .frame_start (frame_start),
    .clr_status  (clr_status),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor on the falling edge: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) vld_cnt++;
      if (frame_err) ferr_cnt++;
      if (m_valid && m_ready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          chk("m_data", 32'(m_data), 32'(e));
          $display("word out %02h expected %02h", m_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first n bits of w, LSB-first, frame_start on bit 0.
  task automatic send_bits(input logic [WIDTH-1:0] w, input int n, input int gapmax, input bit rdy_last);
    for (int i = 0; i < n; i++) begin
      serial_data = w[i];
      bit_en      = 1'b1;
      frame_start = (i == 0);
      if (rdy_last && i == WIDTH - 1) m_ready = 1'b1;
      tick();
      bit_en      = 1'b0;
      frame_start = 1'b0;
      if (rdy_last && i == WIDTH - 1) m_ready = 1'b0;
      chk("busy", 32'(busy), 32'(i != WIDTH - 1));
      if (i != n - 1 && gapmax > 0) begin
        int g;
        g = $urandom_range(gapmax, 0);
        for (int k = 0; k < g; k++) begin
          tick();
          chk("busy_gap", 32'(busy), 32'd1);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    tick();
    chk("valid_after_drain", 32'(m_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Contiguous word
    m_ready = 1'b1;
    vld_cnt = 0;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, WIDTH, 0, 1'b0);
    chk("valid_one_after_last", 32'(m_valid), 32'd1);
    chk("data_one_after_last", 32'(m_data), 32'hA5);
    drain();
    chk("valid_cycles", 32'(vld_cnt), 32'd1);

    // Random gaps
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, WIDTH, 5, 1'b0);
    drain();
    chk("no_frame_err", 32'(ferr_cnt), 32'd0);

    // Overflow with stalled consumer
    m_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_bits(8'h11, WIDTH, 0, 1'b0);
    send_bits(8'h22, WIDTH, 0, 1'b0);
    chk("no_ovf_yet", 32'(overflow), 32'd0);
    send_bits(8'h33, WIDTH, 0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("head_0x11", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    drain();
    chk("overflow_sticky", 32'(overflow), 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("overflow_clr", 32'(overflow), 32'd0);

    // Abort then a clean frame
    ferr_cnt = 0;
    send_bits(8'hFF, 4, 0, 1'b0);
    exp_q.push_back(8'hF0);
    send_bits(8'hF0, WIDTH, 0, 1'b0);
    drain();
    chk("frame_err_pulses", 32'(ferr_cnt), 32'd1);

    // Full FIFO with a pop at the completion edge
    m_ready = 1'b0;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    send_bits(8'h44, WIDTH, 0, 1'b0);
    send_bits(8'h55, WIDTH, 0, 1'b0);
    send_bits(8'h66, WIDTH, 0, 1'b1);
    chk("coincide_no_ovf", 32'(overflow), 32'd0);
    chk("coincide_head", 32'(m_data), 32'h55);
    m_ready = 1'b1;
    drain();

    // Reset mid-frame with a queued word
    m_ready = 1'b0;
    send_bits(8'h77, WIDTH, 0, 1'b0);
    send_bits(8'h0F, 5, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_data", 32'(m_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, WIDTH, 0, 1'b0);
    drain();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
